psum_out_scheduler: RTL

- Round-robin scheduler that shares the single psum output packer among NUM_LANES PE-column result lanes, each producing 1-bit psums.
- Serializes granted bits onto the packer's in_valid/in_data, counts bits against a per-layer total, then issues the packer's layer_finish pulse.
- Sits between the PE array output lanes and the psum packer that feeds the AXI-Stream master.

---
 rtl/psum_out_scheduler_pkg.sv | 21 ++
 rtl/psum_out_scheduler_rr_arbiter.sv | 36 +++
 rtl/psum_out_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/psum_out_scheduler_pkg.sv
// Shared types and constants for the psum output scheduler.
package psum_out_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] OP_CONV    = 2'd0;
  localparam logic [1:0] OP_POOL    = 2'd1;
  localparam logic [1:0] OP_FC      = 2'd2;
  localparam logic [1:0] OP_ELTWISE = 2'd3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_out_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after 'last'.
module rr_arbiter
  import psum_out_scheduler_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..N visit every lane once, ending on 'last' itself.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (en) begin
      for (int unsigned off = 1; off <= N; off++) begin
        cand = IDX_W'((32'(last) + off) % N);
        if (!grant_any && req[cand]) begin
          grant_any   = 1'b1;
          grant_idx   = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/psum_out_scheduler.sv
// Shares the psum packer among NUM_LANES 1-bit result lanes and closes each layer.
module psum_out_scheduler
  import psum_out_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           cfg_operation,
  input  logic [CNT_WIDTH-1:0] cfg_total_bits,
  input  logic                 hold,
  input  logic [NUM_LANES-1:0] lane_valid,
  input  logic [NUM_LANES-1:0] lane_data,
  output logic [NUM_LANES-1:0] lane_ready,
  output logic                 pk_in_valid,
  output logic                 pk_in_data,
  output logic [1:0]           pk_operation,
  output logic                 pk_layer_finish,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] bits_sent
);

  localparam int unsigned IDX_W = idx_width(NUM_LANES);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_LANES-1:0] grant;
  logic                 grant_any;
  logic                 arb_en;
  logic                 at_total;
  logic                 last_bit;
  logic [CNT_WIDTH-1:0] total_q;
  logic [1:0]           op_q;

  assign at_total = (bits_sent == total_q);
  assign last_bit = ((bits_sent + CNT_WIDTH'(1)) == total_q);
  // The at_total guard keeps bits_sent saturated even if RUN were lingering.
  assign arb_en   = (state == ST_RUN) && !hold && !at_total;

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .req       (lane_valid),
    .en        (arb_en),
    .last      (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign lane_ready   = grant;
  assign pk_operation = op_q;
  assign busy         = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (cfg_total_bits == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (grant_any && last_bit) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN:  state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are registered from state_nxt so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr             <= '0;
      total_q         <= '0;
      op_q            <= '0;
      bits_sent       <= '0;
      pk_in_valid     <= 1'b0;
      pk_in_data      <= 1'b0;
      pk_layer_finish <= 1'b0;
      done            <= 1'b0;
    end else begin
      pk_in_valid     <= grant_any;
      pk_in_data      <= grant_any & lane_data[grant_idx];
      pk_layer_finish <= (state_nxt == ST_FINISH);
      done            <= (state_nxt == ST_DONE);
      if (state == ST_IDLE && start) begin
        op_q      <= cfg_operation;
        total_q   <= cfg_total_bits;
        bits_sent <= '0;
      end
      if (grant_any) begin
        ptr       <= grant_idx;
        bits_sent <= bits_sent + CNT_WIDTH'(1);
      end
      if (state == ST_DONE) begin
        ptr <= '0;
      end
    end
  end

endmodule
